// File: rtl/muller_c_pkg.sv
// Shared types and constants for the C-element handshake driver.
// Holds the FSM state encoding, error codes and default widths.
package muller_c_pkg;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_TO_W        = 8;
    localparam int DEF_CNT_W       = 16;
    localparam int SKEW_W          = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RISE_A = 3'd1,
        ST_RISE_B = 3'd2,
        ST_FALL_A = 3'd3,
        ST_FALL_B = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } hs_state_e;

    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_PREMATURE = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT   = 2'd2;
    localparam logic [1:0] ERR_STUCK     = 2'd3;

endpackage

// File: rtl/c_sync.sv
// Multi-flop synchronizer for the asynchronous C-element output.
// Every flop resets to 0.
module c_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/c_elem_hs_driver.sv
// Four-phase handshake driver for a Muller C-element with programmable
// request skew, C-element semantic checking, timeout and handshake counter.
module c_elem_hs_driver
    import muller_c_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int TO_W        = DEF_TO_W,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             start,
    input  logic [3:0]       skew,
    input  logic [TO_W-1:0]  timeout,
    input  logic             clear,
    input  logic             c_in,
    output logic             req_a,
    output logic             req_b,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] hs_count
);

    // One counter serves both the skew delay and the response timeout.
    localparam int CW = (TO_W > SKEW_W) ? TO_W : SKEW_W;

    logic             c_s;
    hs_state_e        state_q;
    logic [CW-1:0]    wait_q;
    logic [CW-1:0]    wait_inc;
    logic [CW-1:0]    skew_q;
    logic [CW-1:0]    timeout_q;
    logic             req_a_q;
    logic             req_b_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic [1:0]       err_code_q;
    logic [CNT_W-1:0] hs_count_q;
    logic             timed_out;

    c_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i (wb_clk_i),
        .rst_i (wb_rst_i),
        .d_i   (c_in),
        .q_o   (c_s)
    );

    assign wait_inc  = (&wait_q) ? wait_q : wait_q + CW'(1);
    assign timed_out = (timeout_q != '0) && (wait_q == timeout_q);

    // wait_q reloads to 1 on every transition, so it equals the number of
    // edges spent in the current state at the moment the FSM samples it.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= ST_IDLE;
            wait_q     <= '0;
            skew_q     <= '0;
            timeout_q  <= '0;
            req_a_q    <= 1'b0;
            req_b_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            hs_count_q <= '0;
        end else begin
            done_q <= 1'b0;
            wait_q <= wait_inc;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        skew_q    <= CW'(skew);
                        timeout_q <= CW'(timeout);
                        wait_q    <= CW'(1);
                        busy_q    <= 1'b1;
                        if (c_s) begin
                            state_q    <= ST_ERR;
                            err_q      <= 1'b1;
                            err_code_q <= ERR_STUCK;
                        end else if (skew == '0) begin
                            state_q <= ST_RISE_B;
                            req_a_q <= 1'b1;
                            req_b_q <= 1'b1;
                        end else begin
                            state_q <= ST_RISE_A;
                            req_a_q <= 1'b1;
                        end
                    end
                end
                ST_RISE_A: begin
                    if (c_s) begin
                        state_q    <= ST_ERR;
                        req_a_q    <= 1'b0;
                        req_b_q    <= 1'b0;
                        err_q      <= 1'b1;
                        err_code_q <= ERR_PREMATURE;
                    end else if (wait_q == skew_q) begin
                        state_q <= ST_RISE_B;
                        wait_q  <= CW'(1);
                        req_b_q <= 1'b1;
                    end
                end
                ST_RISE_B: begin
                    if (c_s) begin
                        wait_q  <= CW'(1);
                        req_a_q <= 1'b0;
                        if (skew_q == '0) begin
                            state_q <= ST_FALL_B;
                            req_b_q <= 1'b0;
                        end else begin
                            state_q <= ST_FALL_A;
                        end
                    end else if (timed_out) begin
                        state_q    <= ST_ERR;
                        req_a_q    <= 1'b0;
                        req_b_q    <= 1'b0;
                        err_q      <= 1'b1;
                        err_code_q <= ERR_TIMEOUT;
                    end
                end
                ST_FALL_A: begin
                    if (!c_s) begin
                        state_q    <= ST_ERR;
                        req_a_q    <= 1'b0;
                        req_b_q    <= 1'b0;
                        err_q      <= 1'b1;
                        err_code_q <= ERR_PREMATURE;
                    end else if (wait_q == skew_q) begin
                        state_q <= ST_FALL_B;
                        wait_q  <= CW'(1);
                        req_b_q <= 1'b0;
                    end
                end
                ST_FALL_B: begin
                    if (!c_s) begin
                        state_q <= ST_DONE;
                        wait_q  <= CW'(1);
                    end else if (timed_out) begin
                        state_q    <= ST_ERR;
                        req_a_q    <= 1'b0;
                        req_b_q    <= 1'b0;
                        err_q      <= 1'b1;
                        err_code_q <= ERR_TIMEOUT;
                    end
                end
                ST_DONE: begin
                    state_q    <= ST_IDLE;
                    wait_q     <= CW'(1);
                    busy_q     <= 1'b0;
                    done_q     <= 1'b1;
                    hs_count_q <= hs_count_q + CNT_W'(1);
                end
                ST_ERR: begin
                    req_a_q <= 1'b0;
                    req_b_q <= 1'b0;
                    if (clear) begin
                        state_q    <= ST_IDLE;
                        wait_q     <= CW'(1);
                        busy_q     <= 1'b0;
                        err_q      <= 1'b0;
                        err_code_q <= ERR_NONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    req_a_q <= 1'b0;
                    req_b_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign req_a    = req_a_q;
    assign req_b    = req_b_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign err_code = err_code_q;
    assign hs_count = hs_count_q;

endmodule

// File: tb/tb_c_elem_hs_driver.sv
// Directed bench for c_elem_hs_driver driving a behavioural C-element model
// that can be ideal, follow A alone, or be stuck at 0 or 1.
module tb_c_elem_hs_driver;

    localparam int SYNC_STAGES = 2;
    localparam int TO_W        = 8;
    localparam int CNT_W       = 4;

    localparam int M_IDEAL    = 0;
    localparam int M_FOLLOW_A = 1;
    localparam int M_STUCK0   = 2;
    localparam int M_STUCK1   = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             start = 1'b0;
    logic [3:0]       skew = 4'd0;
    logic [TO_W-1:0]  timeout = '0;
    logic             clear = 1'b0;
    logic             c_in = 1'b0;
    logic             req_a;
    logic             req_b;
    logic             busy;
    logic             done;
    logic             err;
    logic [1:0]       err_code;
    logic [CNT_W-1:0] hs_count;

    int mode = M_IDEAL;
    int checks = 0;
    int fails = 0;

    always #5 clk = ~clk;

    c_elem_hs_driver #(
        .SYNC_STAGES (SYNC_STAGES),
        .TO_W        (TO_W),
        .CNT_W       (CNT_W)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .start    (start),
        .skew     (skew),
        .timeout  (timeout),
        .clear    (clear),
        .c_in     (c_in),
        .req_a    (req_a),
        .req_b    (req_b),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_code (err_code),
        .hs_count (hs_count)
    );

    // Behavioural C-element: ideal mode holds while inputs disagree.
    always @(req_a, req_b, mode) begin
        case (mode)
            M_IDEAL:    if (req_a === req_b) c_in = req_a;
            M_FOLLOW_A: c_in = req_a;
            M_STUCK0:   c_in = 1'b0;
            default:    c_in = 1'b1;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        start = 1'b0;
        clear = 1'b0;
        mode  = M_IDEAL;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Tick n=1 is the first edge after start is driven. Records the tick at
    // which each request edge, done and err are first seen. skew/timeout are
    // scrambled after launch so any failure to latch them shows up.
    task automatic run_hs(input logic [3:0] sk, input logic [TO_W-1:0] to, input int inject_at,
                          output int a_rise, output int b_rise, output int a_fall,
                          output int b_fall, output int done_at, output int err_at);
        a_rise = -1; b_rise = -1; a_fall = -1; b_fall = -1; done_at = -1; err_at = -1;
        skew    = sk;
        timeout = to;
        start   = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            tick();
            if (n == 1) begin
                start   = 1'b0;
                skew    = 4'hF;
                timeout = 8'd1;
            end
            if (n == inject_at) start = 1'b1;
            if (n == inject_at + 1) start = 1'b0;
            if (req_a === 1'b1 && a_rise < 0) a_rise = n;
            if (req_b === 1'b1 && b_rise < 0) b_rise = n;
            if (req_a === 1'b0 && a_rise >= 0 && a_fall < 0) a_fall = n;
            if (req_b === 1'b0 && b_rise >= 0 && b_fall < 0) b_fall = n;
            if (done === 1'b1 && done_at < 0) done_at = n;
            if (err === 1'b1 && err_at < 0) err_at = n;
            if (done_at >= 0 || err_at >= 0) break;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({req_a, req_b} !== 2'b00) begin
            fails++;
            $display("FAIL reset_req: req_a,req_b=%b expected 00", {req_a, req_b});
        end
        checks++;
        if ({busy, done, err} !== 3'b000) begin
            fails++;
            $display("FAIL reset_flags: busy,done,err=%b expected 000", {busy, done, err});
        end
        checks++;
        if (err_code !== 2'd0 || hs_count !== 4'd0) begin
            fails++;
            $display("FAIL reset_regs: err_code=%0d hs_count=%0d expected 0 0", err_code, hs_count);
        end
        rst = 1'b0;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_ideal_skew0();
        int ar, br, af, bf, dn, er;
        do_reset();
        run_hs(4'd0, 8'd0, 0, ar, br, af, bf, dn, er);
        checks++;
        if (ar !== 1 || br !== 1) begin
            fails++;
            $display("FAIL skew0_rise: req_a at %0d req_b at %0d expected 1 1", ar, br);
        end
        checks++;
        if (af !== 4 || bf !== 4) begin
            fails++;
            $display("FAIL skew0_fall: req_a at %0d req_b at %0d expected 4 4", af, bf);
        end
        checks++;
        if (dn !== 8 || er !== -1) begin
            fails++;
            $display("FAIL skew0_done: done at %0d err at %0d expected 8 -1", dn, er);
        end
        checks++;
        if (hs_count !== 4'd1 || err !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL skew0_final: hs_count=%0d err=%b busy=%b expected 1 0 0", hs_count, err, busy);
        end
        $display("test_ideal_skew0: rise %0d/%0d fall %0d/%0d done %0d", ar, br, af, bf, dn);
    endtask

    task automatic test_skew3();
        int ar, br, af, bf, dn, er;
        do_reset();
        run_hs(4'd3, 8'd0, 0, ar, br, af, bf, dn, er);
        checks++;
        if (ar !== 1 || br !== 4) begin
            fails++;
            $display("FAIL skew3_rise: req_a at %0d req_b at %0d expected 1 4", ar, br);
        end
        checks++;
        if (af !== 7 || bf !== 10) begin
            fails++;
            $display("FAIL skew3_fall: req_a at %0d req_b at %0d expected 7 10", af, bf);
        end
        checks++;
        if (dn !== 14 || hs_count !== 4'd1) begin
            fails++;
            $display("FAIL skew3_done: done at %0d hs_count=%0d expected 14 1", dn, hs_count);
        end
        $display("test_skew3: rise %0d/%0d fall %0d/%0d done %0d", ar, br, af, bf, dn);
    endtask

    task automatic test_premature();
        int ar, br, af, bf, dn, er;
        do_reset();
        mode = M_FOLLOW_A;
        run_hs(4'd4, 8'd0, 0, ar, br, af, bf, dn, er);
        checks++;
        if (er !== 4 || br !== -1 || dn !== -1) begin
            fails++;
            $display("FAIL premature_when: err at %0d req_b at %0d done at %0d expected 4 -1 -1", er, br, dn);
        end
        checks++;
        if (err_code !== 2'd1 || {req_a, req_b} !== 2'b00) begin
            fails++;
            $display("FAIL premature_code: err_code=%0d reqs=%b expected 1 00", err_code, {req_a, req_b});
        end
        repeat (3) tick();
        checks++;
        if (err !== 1'b1 || busy !== 1'b1 || err_code !== 2'd1) begin
            fails++;
            $display("FAIL premature_sticky: err=%b busy=%b code=%0d expected 1 1 1", err, busy, err_code);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++;
        if (err !== 1'b0 || err_code !== 2'd0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL premature_clear: err=%b code=%0d busy=%b expected 0 0 0", err, err_code, busy);
        end
        mode = M_IDEAL;
        $display("test_premature: err at %0d", er);
    endtask

    task automatic test_timeout();
        int ar, br, af, bf, dn, er;
        do_reset();
        run_hs(4'd0, 8'd0, 0, ar, br, af, bf, dn, er);
        mode = M_STUCK0;
        run_hs(4'd0, 8'd10, 0, ar, br, af, bf, dn, er);
        checks++;
        if (er !== 11 || dn !== -1) begin
            fails++;
            $display("FAIL timeout_when: err at %0d done at %0d expected 11 -1", er, dn);
        end
        checks++;
        if (err_code !== 2'd2 || hs_count !== 4'd1 || {req_a, req_b} !== 2'b00) begin
            fails++;
            $display("FAIL timeout_state: code=%0d hs_count=%0d reqs=%b expected 2 1 00",
                     err_code, hs_count, {req_a, req_b});
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        mode = M_IDEAL;
        $display("test_timeout: err at %0d code %0d", er, err_code);
    endtask

    task automatic test_stuck_high();
        int ar, br, af, bf, dn, er;
        do_reset();
        mode = M_STUCK1;
        repeat (3) tick();
        run_hs(4'd2, 8'd0, 0, ar, br, af, bf, dn, er);
        repeat (2) tick();
        checks++;
        if (er !== 1 || err_code !== 2'd3) begin
            fails++;
            $display("FAIL stuck_code: err at %0d code=%0d expected 1 3", er, err_code);
        end
        checks++;
        if (ar !== -1 || br !== -1 || {req_a, req_b} !== 2'b00) begin
            fails++;
            $display("FAIL stuck_reqs: req_a at %0d req_b at %0d expected never", ar, br);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        mode = M_IDEAL;
        $display("test_stuck_high: err at %0d", er);
    endtask

    task automatic test_back_to_back();
        int ar, br, af, bf, dn, er;
        do_reset();
        for (int h = 1; h <= 17; h++) begin
            run_hs(4'd0, 8'd0, (h == 5) ? 3 : 0, ar, br, af, bf, dn, er);
            checks++;
            if (dn !== 8 || er !== -1) begin
                fails++;
                $display("FAIL btb_done_%0d: done at %0d err at %0d expected 8 -1", h, dn, er);
            end
            if (h == 5) begin
                tick();
                tick();
                checks++;
                if (busy !== 1'b0 || hs_count !== 4'd5) begin
                    fails++;
                    $display("FAIL btb_extra_start: busy=%b hs_count=%0d expected 0 5", busy, hs_count);
                end
            end
            if (h == 16) begin
                checks++;
                if (hs_count !== 4'd0 || err !== 1'b0) begin
                    fails++;
                    $display("FAIL btb_wrap: hs_count=%0d err=%b expected 0 0", hs_count, err);
                end
            end
        end
        checks++;
        if (hs_count !== 4'd1 || err !== 1'b0) begin
            fails++;
            $display("FAIL btb_final: hs_count=%0d err=%b expected 1 0", hs_count, err);
        end
        $display("test_back_to_back: hs_count %0d", hs_count);
    endtask

    task automatic test_async_reset();
        do_reset();
        mode = M_STUCK0;
        skew = 4'd0;
        timeout = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        checks++;
        if ({req_a, req_b, busy} !== 3'b111) begin
            fails++;
            $display("FAIL arst_pre: reqs,busy=%b expected 111", {req_a, req_b, busy});
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({req_a, req_b, busy, done, err} !== 5'b0 || err_code !== 2'd0 || hs_count !== 4'd0) begin
            fails++;
            $display("FAIL arst_now: reqs,busy,done,err=%b code=%0d cnt=%0d expected all 0",
                     {req_a, req_b, busy, done, err}, err_code, hs_count);
        end
        repeat (3) tick();
        rst = 1'b0;
        mode = M_IDEAL;
        repeat (10) tick();
        checks++;
        if (done !== 1'b0 || hs_count !== 4'd0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL arst_after: done=%b hs_count=%0d busy=%b expected 0 0 0", done, hs_count, busy);
        end
        $display("test_async_reset done");
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_ideal_skew0();
        test_skew3();
        test_premature();
        test_timeout();
        test_stuck_high();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/c_elem_hs_driver.md
# c_elem_hs_driver

Clocked four-phase handshake driver that sits directly upstream of the Muller C-element. It generates the element's two request inputs with a programmable skew and samples the element's output through a synchronizer. It checks C-element semantics on every cycle: the output holds while the inputs disagree and follows them once they agree. Completed handshakes are counted, and any violation or timeout latches a sticky error.

## Interface
Parameters:
- SYNC_STAGES, 2, flops in the c_in synchronizer (≥2)
- TO_W, 8, width of timeout field
- CNT_W, 16, width of handshake counter

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse; begins one handshake when idle
- skew  in  4  cycles between first and second request edge (0 = simultaneous)
- timeout  in  TO_W  max cycles to wait for c_in to follow; 0 = no timeout
- clear  in  1  clears err and err_code; counter untouched
- c_in  in  1  C-element output, asynchronous to wb_clk_i
- req_a  out  1  C-element input A
- req_b  out  1  C-element input B
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse on handshake completion
- err  out  1  sticky error flag
- err_code  out  2  0 none, 1 premature output change, 2 timeout, 3 c_in high at start
- hs_count  out  CNT_W  completed handshakes, wraps modulo 2^CNT_W

## Operation
- c_s is c_in after SYNC_STAGES flops. All checks use c_s only.
- FSM states: IDLE, RISE_A, RISE_B, FALL_A, FALL_B, DONE, ERR.
- IDLE (req_a=req_b=0):
  - start with c_s=1 → ERR, code 3.
  - start with c_s=0 and skew=0 → RISE_B.
  - start otherwise → RISE_A.
  - start is ignored when not in IDLE.
- RISE_A: req_a=1, req_b=0 for skew cycles.
  - c_s=1 → ERR, code 1.
  - When the skew counter expires → RISE_B.
- RISE_B: req_a=req_b=1; wait for c_s=1.
  - c_s=1 → FALL_A, or FALL_B if skew=0.
  - Wait counter reaches timeout → ERR, code 2.
- FALL_A: req_a=0, req_b=1 for skew cycles.
  - c_s=0 → ERR, code 1.
  - When the skew counter expires → FALL_B.
- FALL_B: req_a=req_b=0; wait for c_s=0 (same timeout rule) → DONE.
- DONE: done=1, hs_count increments → IDLE.
- ERR: requests low, err=1. Stays until clear; clear → IDLE with err=0 and err_code=0.
- skew and timeout are latched on start. Changes mid-handshake have no effect.
- The wait counter reloads on every state entry and saturates.
- clear outside ERR is ignored.

## Timing
- Reset values: req_a=0, req_b=0, busy=0, done=0, err=0, err_code=0, hs_count=0, synchronizer flops 0, FSM in IDLE.
- Reset asserted mid-handshake immediately drops both requests. No done and no count follow.
- Requests are registered outputs. They change one cycle after the FSM transition that causes the change.
- Start to req_a high: 1 cycle.
- Minimum handshake with an ideal element, skew=0, SYNC_STAGES=2: start to done = 1 + (1+2) + (1+2) + 1 = 8 cycles.
- Each nonzero skew value adds 2·skew cycles.
- Timeout fires on the cycle the wait count equals timeout. timeout=1 therefore always fails with SYNC_STAGES≥2.
- hs_count wraps from all-ones to 0 without raising an error.

## Structure
- Shared package muller_c_pkg holds:
  - the FSM state enum
  - err_code constants ERR_NONE, ERR_PREMATURE, ERR_TIMEOUT, ERR_STUCK
  - default widths
- One sub-module: c_sync, an SYNC_STAGES-deep flop chain with async active-high reset to 0.

## Test plan
- Ideal C-element model, skew=0, timeout=0, one start → req_a and req_b rise together, done 8 cycles after start, hs_count=1, err=0.
- skew=3, ideal model → req_a leads req_b by 3 cycles on both edges; done at cycle 14; hs_count=1.
- Faulty model that follows A alone, skew=4 → err=1, err_code=1 during RISE_A, requests low. A later clear gives err=0, busy=0.
- Model stuck at 0, timeout=10 → err_code=2 ten cycles into RISE_B. No done pulse; hs_count unchanged.
- c_in held 1 while idle, start → err_code=3 one cycle after start; requests never assert.
- CNT_W=4, 17 back-to-back handshakes with a start pulse inserted mid-handshake → extra start ignored, hs_count=1 after wrap. Then assert wb_rst_i mid-RISE_B → all outputs 0 asynchronously.
